// File: rtl/event_source_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : event_source_pkg
//  Description : Shared types and default sizing for the event_source block.
//                Holds the FSM state enum and the default parameter values
//                used by event_source and its down_counter.
//  Revision    : 1.0  initial release
// ============================================================================
package event_source_pkg;

  localparam int DEF_COUNTER_WIDTH  = 64;
  localparam int DEF_GAP_WIDTH      = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    GAP    = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage : event_source_pkg
`default_nettype wire

// File: rtl/event_source_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter
//  Description : Loadable down counter with a zero flag. Counts down by one
//                per enabled cycle and saturates at zero. A load has priority
//                over a decrement.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                load/load_val - synchronous load of a new count
//                dec           - decrement enable (ignored when at zero)
//                zero          - count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule : down_counter
`default_nettype wire

// File: rtl/event_source.sv
`default_nettype none
// ============================================================================
//  Module      : event_source
//  Description : Issues a programmed number of events to a monitor, with an
//                optional idle gap between events, then waits for the
//                monitor count to settle and checks that it advanced by
//                exactly the number of events sent.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                go              - start pulse (accepted in IDLE only)
//                num_events      - events to issue (latched on go)
//                gap_cycles      - idle cycles between events (latched on go)
//                en / ready      - event handshake, transfer on en && ready
//                mon_count       - monitor count
//                mon_count_valid - monitor count is settled
//                sent            - events transferred in current/last run
//                busy            - not in IDLE
//                done            - one-cycle end-of-run pulse
//                pass / timeout  - result of the last run
//  Revision    : 1.0  initial release
// ============================================================================
module event_source
  import event_source_pkg::*;
#(
  parameter int COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
  parameter int GAP_WIDTH      = DEF_GAP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic [COUNTER_WIDTH-1:0] num_events,
  input  logic [GAP_WIDTH-1:0]     gap_cycles,
  output logic                     en,
  input  logic                     ready,
  input  logic [COUNTER_WIDTH-1:0] mon_count,
  input  logic                     mon_count_valid,
  output logic [COUNTER_WIDTH-1:0] sent,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [COUNTER_WIDTH-1:0] r_num;
  logic [GAP_WIDTH-1:0]     r_gap;
  logic [COUNTER_WIDTH-1:0] r_base;
  logic [COUNTER_WIDTH-1:0] r_sent;
  logic                     r_pass;
  logic                     r_timeout;

  logic                     w_accept;
  logic                     w_xfer;
  logic                     w_last;
  logic [COUNTER_WIDTH-1:0] w_sent_inc;
  logic [COUNTER_WIDTH-1:0] w_expect;
  logic                     w_drain_enter;
  logic                     w_gap_load;
  logic                     w_gap_zero;
  logic                     w_to_zero;

  assign w_accept   = (r_state == IDLE) && go && mon_count_valid;
  assign w_xfer     = (r_state == SEND) && ready;
  assign w_sent_inc = r_sent + COUNTER_WIDTH'(1);
  assign w_last     = w_xfer && (w_sent_inc == r_num);
  // Expected final monitor count; wraps naturally at COUNTER_WIDTH.
  assign w_expect   = r_base + r_num;

  assign w_drain_enter = (w_accept && (num_events == '0)) || w_last;
  assign w_gap_load    = w_xfer && !w_last && (r_gap != '0);

  // Gap counter is loaded with gap-1 so that the zero flag marks the final
  // GAP cycle, giving exactly gap idle cycles.
  down_counter #(
    .WIDTH (GAP_WIDTH)
  ) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_gap_load),
    .load_val (r_gap - GAP_WIDTH'(1)),
    .dec      (r_state == GAP),
    .zero     (w_gap_zero)
  );

  // Timeout counter: loaded with TIMEOUT_CYCLES-1 on DRAIN entry; the zero
  // flag marks the last permitted DRAIN cycle without mon_count_valid.
  down_counter #(
    .WIDTH (TW)
  ) u_to_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_drain_enter),
    .load_val (TW'(TIMEOUT_CYCLES - 1)),
    .dec      ((r_state == DRAIN) && !mon_count_valid),
    .zero     (w_to_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (num_events == '0) ? DRAIN : SEND;
        end
      end
      SEND: begin
        if (ready) begin
          if (w_last) begin
            w_state_nxt = DRAIN;
          end else if (r_gap != '0) begin
            w_state_nxt = GAP;
          end else begin
            w_state_nxt = SEND;
          end
        end
      end
      GAP: begin
        if (w_gap_zero) begin
          w_state_nxt = SEND;
        end
      end
      DRAIN: begin
        if (mon_count_valid || w_to_zero) begin
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num     <= '0;
      r_gap     <= '0;
      r_base    <= '0;
      r_sent    <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_num     <= num_events;
        r_gap     <= gap_cycles;
        r_base    <= mon_count;
        r_sent    <= '0;
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
      end else if (w_xfer) begin
        r_sent <= w_sent_inc;
      end else if (r_state == DRAIN) begin
        if (mon_count_valid) begin
          r_pass <= (mon_count == w_expect);
        end else if (w_to_zero) begin
          r_pass    <= 1'b0;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign en      = (r_state == SEND);
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == FINISH);
  assign sent    = r_sent;
  assign pass    = r_pass;
  assign timeout = r_timeout;

endmodule : event_source
`default_nettype wire

// File: tb/tb_event_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_source
//  Description : Self-checking bench for event_source. A behavioural monitor
//                drives ready/mon_count/mon_count_valid in ideal, slow, fast
//                and stub flavours; a run-level reference model predicts the
//                outputs every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_event_source;

  localparam int CW = 16;
  localparam int GW = 8;
  localparam int TO = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [CW-1:0] num_events;
  logic [GW-1:0] gap_cycles;
  logic          en;
  logic          ready;
  logic [CW-1:0] mon_count;
  logic          mon_count_valid;
  logic [CW-1:0] sent;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;

  always #5 clk = ~clk;

  event_source #(
    .COUNTER_WIDTH  (CW),
    .GAP_WIDTH      (GW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .go              (go),
    .num_events      (num_events),
    .gap_cycles      (gap_cycles),
    .en              (en),
    .ready           (ready),
    .mon_count       (mon_count),
    .mon_count_valid (mon_count_valid),
    .sent            (sent),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timeout         (timeout)
  );

  // ---------------- behavioural monitor ----------------
  // mode 0: ideal (ready=1, valid=1); 1: slow (ready 2 of 3 cycles, valid
  // after 4 quiet cycles); 2: fast with depth 64 (drains one per 2 cycles).
  logic [1:0]    mode = 2'd0;
  logic          stuck = 1'b0;
  logic [CW-1:0] off = '0;
  logic          mon_load = 1'b0;
  logic [CW-1:0] mon_load_val = '0;
  logic [CW-1:0] mon_cnt = '0;
  logic [1:0]    ph = 2'd0;
  logic          tgl = 1'b0;
  int            fill = 0;
  int            quiet = 100;

  always @(posedge clk) begin
    ph  <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
    tgl <= ~tgl;
    if (mon_load) mon_cnt <= mon_load_val;
    else if (en && ready) mon_cnt <= mon_cnt + 1'b1;
    fill <= fill + ((en && ready) ? 1 : 0) - ((tgl && fill > 0) ? 1 : 0);
    if (en && ready) quiet <= 0;
    else if (quiet < 100) quiet <= quiet + 1;
  end

  assign ready = (mode == 2'd2) ? (fill < 64) :
                 (mode == 2'd1) ? (ph != 2'd0) : 1'b1;
  assign mon_count_valid = !stuck && ((mode == 2'd2) ? (fill == 0) :
                                      (mode == 2'd1) ? (quiet >= 4) : 1'b1);
  assign mon_count = mon_cnt + off;

  // ---------------- reference model ----------------
  // A run is: remaining events to send, a pending idle gap, a settle wait,
  // then a single done cycle.
  logic          m_run, m_drain, m_fin, m_pass, m_to;
  logic [CW-1:0] m_num, m_base, m_sent, m_left;
  logic [GW-1:0] m_gap, m_gw;
  int            m_age;
  logic          m_idle, m_en;

  assign m_idle = !m_run && !m_drain && !m_fin;
  assign m_en   = m_run && (m_gw == '0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_drain <= 0; m_fin <= 0; m_pass <= 0; m_to <= 0;
      m_num <= '0; m_base <= '0; m_sent <= '0; m_left <= '0;
      m_gap <= '0; m_gw <= '0; m_age <= 0;
    end else begin
      m_fin <= 1'b0;
      if (m_idle) begin
        if (go && mon_count_valid) begin
          m_num  <= num_events;
          m_gap  <= gap_cycles;
          m_base <= mon_count;
          m_sent <= '0;
          m_pass <= 1'b0;
          m_to   <= 1'b0;
          m_gw   <= '0;
          m_age  <= 0;
          m_left <= num_events;
          if (num_events == '0) m_drain <= 1'b1;
          else m_run <= 1'b1;
        end
      end else if (m_run) begin
        if (m_gw != '0) begin
          m_gw <= m_gw - 1'b1;
        end else if (ready) begin
          m_sent <= m_sent + 1'b1;
          m_left <= m_left - 1'b1;
          if (m_left == 1) begin
            m_run   <= 1'b0;
            m_drain <= 1'b1;
            m_age   <= 0;
          end else begin
            m_gw <= m_gap;
          end
        end
      end else if (m_drain) begin
        if (mon_count_valid) begin
          m_pass  <= (mon_count == CW'(m_base + m_num));
          m_drain <= 1'b0;
          m_fin   <= 1'b1;
        end else if (m_age + 1 == TO) begin
          m_to    <= 1'b1;
          m_pass  <= 1'b0;
          m_drain <= 1'b0;
          m_fin   <= 1'b1;
        end else begin
          m_age <= m_age + 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  int en_cnt, xfer_cnt, stall_cnt, done_cnt, run_cur, run_max;
  int low_cur, gmin, gmax, d_cur, drain_len, last_cycles;
  bit seen;

  task automatic clr_trk();
    en_cnt = 0; xfer_cnt = 0; stall_cnt = 0; done_cnt = 0;
    run_cur = 0; run_max = 0; low_cur = 0; gmin = 1000; gmax = 0;
    d_cur = 0; drain_len = -1; seen = 0;
  endtask

  task automatic start_run(input logic [CW-1:0] n, input logic [GW-1:0] g);
    @(negedge clk);
    num_events = n;
    gap_cycles = g;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    last_cycles = n;
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_%s: done=%0b after %0d cycles, want done=1", nm, done, budget);
    end
  endtask

  task automatic mon_set(input logic [CW-1:0] v);
    @(negedge clk);
    mon_load = 1'b1;
    mon_load_val = v;
    @(negedge clk);
    mon_load = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; go = 1'b0; num_events = '0; gap_cycles = '0;
    clr_trk();

    fork
      forever begin
        @(negedge clk);
        chk("en", en, m_en);
        chk("busy", busy, !m_idle);
        chk("done", done, m_fin);
        chk("sent", sent, m_sent);
        chk("pass", pass, m_pass);
        chk("timeout", timeout, m_to);
        if (en === 1'b1) begin
          en_cnt++;
          run_cur++;
          if (run_cur > run_max) run_max = run_cur;
          if (ready) xfer_cnt++; else stall_cnt++;
          if (seen && low_cur > 0) begin
            if (low_cur < gmin) gmin = low_cur;
            if (low_cur > gmax) gmax = low_cur;
          end
          low_cur = 0;
          d_cur   = 0;
          seen    = 1;
        end else begin
          run_cur = 0;
          if (busy && !done) begin
            if (seen) low_cur++;
            d_cur++;
          end
        end
        if (done === 1'b1) begin
          done_cnt++;
          drain_len = d_cur;
          d_cur = 0;
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", sent, 0);
    rst = 1'b0;
    mon_set(16'h0100);

    // 10 events, no gap, ideal monitor
    clr_trk();
    start_run(16'd10, 8'd0);
    wait_done(100, "a");
    settle();
    chk("a_sent", sent, 10);
    chk("a_pass", pass, 1);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_en_run", run_max, 10);
    chk("a_mon", mon_cnt, 16'h010A);

    // 5 events, gap 3, slow monitor, with a stray go mid-run
    mode = 2'd1;
    clr_trk();
    start_run(16'd5, 8'd3);
    repeat (3) @(negedge clk);
    num_events = 16'd9; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done(200, "b");
    settle();
    chk("b_gmin", gmin, 3);
    chk("b_gmax", gmax, 3);
    chk("b_sent", sent, 5);
    chk("b_pass", pass, 1);
    chk("b_mon", mon_cnt, 16'h010F);

    // 200 events into a fast monitor of depth 64
    mode = 2'd2;
    clr_trk();
    start_run(16'd200, 8'd0);
    wait_done(2000, "c");
    settle();
    chk("c_sent", sent, 200);
    chk("c_xfer", xfer_cnt, 200);
    chk("c_stalled", stall_cnt > 0, 1);
    chk("c_pass", pass, 1);
    chk("c_mon", mon_cnt, 16'h01D7);

    // valid stuck low after go -> timeout
    mode = 2'd0;
    repeat (200) @(negedge clk);
    clr_trk();
    start_run(16'd3, 8'd0);
    stuck = 1'b1;
    wait_done(TO + 50, "d");
    settle();
    chk("d_timeout", timeout, 1);
    chk("d_pass", pass, 0);
    chk("d_drain_len", drain_len, TO);

    // go ignored while mon_count_valid is low
    start_run(16'd2, 8'd0);
    @(negedge clk);
    chk("e_busy", busy, 0);
    chk("e_timeout_held", timeout, 1);
    stuck = 1'b0;

    // monitor count off by one
    clr_trk();
    start_run(16'd4, 8'd0);
    off = 16'd1;
    wait_done(50, "f");
    settle();
    chk("f_pass", pass, 0);
    chk("f_timeout", timeout, 0);
    off = '0;

    // zero events
    clr_trk();
    start_run(16'd0, 8'd5);
    wait_done(3, "g");
    chk("g_latency_ok", last_cycles <= 3, 1);
    settle();
    chk("g_pass", pass, 1);
    chk("g_sent", sent, 0);

    // wrap of base + num_events
    mon_set(16'hFFFD);
    clr_trk();
    start_run(16'd5, 8'd2);
    wait_done(100, "h");
    settle();
    chk("h_pass", pass, 1);
    chk("h_mon", mon_cnt, 16'h0002);

    // reset during SEND at sent=7
    clr_trk();
    start_run(16'd20, 8'd0);
    n = 0;
    while (sent != 16'd7 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("i_reached7", sent, 7);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("i_en", en, 0);
    chk("i_busy", busy, 0);
    chk("i_sent", sent, 0);
    chk("i_pass", pass, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("i_no_done", done_cnt, 0);
    clr_trk();
    start_run(16'd4, 8'd0);
    wait_done(50, "i");
    settle();
    chk("i_sent4", sent, 4);
    chk("i_pass4", pass, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_event_source
`default_nettype wire
